div: RTL and testbench
======================

// Module: div
// PURPOSE
// - Multi-cycle 32-bit integer divider: responder to the execute stage's divide request (div/divu).
// - EX raises start_i with operands, stalls until ready_o, then writes {HI,LO} = result_o. Remainder -> HI, quotient -> LO.
// - Radix-2 restoring algorithm, one quotient bit per clock. annul_i lets EX abort on flush.
// PARAMETERS
// - WIDTH     32   operand width; result_o is 2*WIDTH
// - CNT_W     6    iteration counter width, >= clog2(WIDTH)+1
// PORTS
// - clk           in   1        rising-edge clock
// - rst_n         in   1        asynchronous, active-low reset
// - signed_div_i  in   1        1 = signed (div), 0 = unsigned (divu); sampled on accept
// - opdata1_i     in   WIDTH    dividend; sampled on accept
// - opdata2_i     in   WIDTH    divisor; sampled on accept
// - start_i       in   1        request; EX holds it high until it has consumed ready_o
// - annul_i       in   1        abort current operation (pipeline flush)
// - result_o      out  2*WIDTH  {remainder, quotient}
// - ready_o       out  1        result_o valid
// BEHAVIOUR
// - One clock; reset asynchronous, active-low. On reset: state=FREE, ready_o=0, result_o=0, counter=0.
// - States: FREE, BYZERO, ON, END (2-bit encoding).
// - FREE: start_i=1 and annul_i=0 -> accept: latch operands.
//   Divisor==0 -> BYZERO. Otherwise -> ON, counter=0.
//   Signed mode loads magnitudes (two's-complement negate of negative operands). Sign flags are latched.
//   start_i=1 with annul_i=1 is ignored; the block stays in FREE.
// - BYZERO: next edge -> END with result_o=0, ready_o=1.
// - ON: each edge shifts the 2*WIDTH+1 work register left by 1.
//   If upper WIDTH+1 bits >= divisor: subtract the divisor and set the quotient LSB=1. Otherwise leave them and set LSB=0.
//   counter increments. The edge that completes iteration WIDTH-1 -> END.
//   In the same edge: result_o = {rem, quo} after sign fixup, ready_o=1.
// - Sign fixup (signed mode only): quotient negated if dividend and divisor signs differ; remainder negated if dividend negative.
//   0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0 (no trap).
// - Latency: the accepting edge plus WIDTH iteration edges, so ready_o is high after the 33rd rising edge counting the accepting one.
//   Divide-by-zero: 2 edges.
// - annul_i=1 in ON or BYZERO -> FREE next edge, ready_o=0, result_o=0. The partial result is discarded.
// - END: ready_o and result_o hold while start_i=1. start_i=0 -> FREE next edge, ready_o=0, result_o=0.
//   annul_i in END also returns to FREE.
// - No new request is accepted outside FREE; back-to-back divides need one FREE cycle in between.
// - Reset mid-operation: immediate return to reset state; no residual state survives.
// CONFIGURATION
// - DIV_EARLY_OUT_EN defined: in FREE, accept with |divisor| > |dividend| (unsigned magnitudes) -> END directly on the accepting edge.
//   In that case result_o = {dividend (original, signed value), 0} and ready_o is high after 1 edge.
//   Divide-by-zero still takes the BYZERO path.
// - DIV_EARLY_OUT_EN undefined: every nonzero-divisor operation takes the full WIDTH iterations. Results are identical in both modes.
// STRUCTURE
// - Shared defines file gains:
//   - state codes DivFree, DivByZero, DivOn, DivEnd
//   - DivResultReady / DivResultNotReady
//   - DivStart / DivStop
//   - DivSigned / DivUnsigned
// - No sub-module. Single FSM block plus a combinational subtract/compare of the upper work bits.
// - Negate logic stays inline.
// TESTING
// - unsigned: 100 / 7 -> ready_o after 33 edges, result_o = {32'd2, 32'd14}; ready holds while start_i=1.
// - signed: -7 / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); 7 / -2 -> quotient -3, remainder +1.
// - divide by zero: 0x1234 / 0, either sign mode -> ready_o after 2 edges, result_o = 0.
// - annul: start 100 / 7, raise annul_i at iteration 10 -> FREE next edge, ready_o stays 0.
//   A new 9 / 3 then completes with quotient 3, remainder 0.
// - handshake/reset: drop start_i in END -> ready_o=0 next edge. Assert rst_n=0 asynchronously in ON -> all outputs 0 immediately.
// - overflow corner: signed 0x80000000 / 0xFFFFFFFF -> {0, 0x80000000}.
//   With DIV_EARLY_OUT_EN, 5 / 9 -> {5, 0} after 1 edge.

Source files
------------

// File: rtl/div_pkg.sv
// Shared state codes and handshake constants for the radix-2 restoring divider.
package div_pkg;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;
   localparam logic DivSigned         = 1'b1;
   localparam logic DivUnsigned       = 1'b0;

endpackage

// File: rtl/div_if.sv
// Request/response bundle between the execute stage (master) and the divider (slave).
interface div_if #(
   parameter int WIDTH = 32
);
   logic                 signed_div;
   logic [WIDTH-1:0]     opdata1;
   logic [WIDTH-1:0]     opdata2;
   logic                 start;
   logic                 annul;
   logic [2*WIDTH-1:0]   result;
   logic                 ready;

   modport master (
      output signed_div, opdata1, opdata2, start, annul,
      input  result, ready
   );

   modport slave (
      input  signed_div, opdata1, opdata2, start, annul,
      output result, ready
   );
endinterface

// File: rtl/div.sv
// Multi-cycle restoring divider, one quotient bit per clock; result = {remainder, quotient}.
// Optional DIV_EARLY_OUT_EN: finish on the accepting edge when |divisor| > |dividend|.
//
// state      | meaning
// DivFree    | idle, outputs cleared, waiting for start without annul
// DivByZero  | divisor was zero; next edge publishes a zero result
// DivOn      | shifting/subtracting, one quotient bit per edge
// DivEnd     | result valid, held until start drops or annul
module div
   import div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic  clk,
   input  logic  rst_n,
   div_if.slave  bus
);

   div_state_e             state;
   logic [CNT_W-1:0]       cnt;
   logic [2*WIDTH:0]       work;
   logic [WIDTH-1:0]       divisor;
   logic                   neg_quo;
   logic                   neg_rem;

   logic                   dvd_neg;
   logic                   dvs_neg;
   logic [WIDTH-1:0]       dvd_mag;
   logic [WIDTH-1:0]       dvs_mag;
   logic [2*WIDTH:0]       shifted;
   logic [WIDTH+1:0]       diff;
   logic                   fits;
   logic [2*WIDTH:0]       work_next;
   logic [WIDTH-1:0]       quo;
   logic [WIDTH-1:0]       rem;
   logic [WIDTH-1:0]       quo_fix;
   logic [WIDTH-1:0]       rem_fix;

   always_comb begin
      dvd_neg = (bus.signed_div == DivSigned) && bus.opdata1[WIDTH-1];
      dvs_neg = (bus.signed_div == DivSigned) && bus.opdata2[WIDTH-1];
      dvd_mag = dvd_neg ? (~bus.opdata1 + WIDTH'(1)) : bus.opdata1;
      dvs_mag = dvs_neg ? (~bus.opdata2 + WIDTH'(1)) : bus.opdata2;

      // Extra top bit of diff acts as the borrow: clear means the divisor fits.
      shifted = {work[2*WIDTH-1:0], 1'b0};
      diff    = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, divisor};
      fits    = ~diff[WIDTH+1];
      work_next = fits ? {diff[WIDTH:0], shifted[WIDTH-1:1], 1'b1} : shifted;

      quo     = work_next[WIDTH-1:0];
      rem     = work_next[2*WIDTH-1:WIDTH];
      quo_fix = neg_quo ? (~quo + WIDTH'(1)) : quo;
      rem_fix = neg_rem ? (~rem + WIDTH'(1)) : rem;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= DivFree;
         cnt        <= '0;
         work       <= '0;
         divisor    <= '0;
         neg_quo    <= 1'b0;
         neg_rem    <= 1'b0;
         bus.result <= '0;
         bus.ready  <= DivResultNotReady;
      end else begin
         case (state)
            DivFree: begin
               bus.result <= '0;
               bus.ready  <= DivResultNotReady;
               if (bus.start == DivStart && !bus.annul) begin
                  neg_quo <= dvd_neg ^ dvs_neg;
                  neg_rem <= dvd_neg;
                  divisor <= dvs_mag;
                  work    <= {(WIDTH+1)'(0), dvd_mag};
                  cnt     <= '0;
                  if (bus.opdata2 == '0) begin
                     state <= DivByZero;
                  end
`ifdef DIV_EARLY_OUT_EN
                  else if (dvs_mag > dvd_mag) begin
                     state      <= DivEnd;
                     bus.result <= {bus.opdata1, WIDTH'(0)};
                     bus.ready  <= DivResultReady;
                  end
`endif
                  else begin
                     state <= DivOn;
                  end
               end
            end
            DivByZero: begin
               if (bus.annul) begin
                  state <= DivFree;
               end else begin
                  state      <= DivEnd;
                  bus.result <= '0;
                  bus.ready  <= DivResultReady;
               end
            end
            DivOn: begin
               if (bus.annul) begin
                  state      <= DivFree;
                  bus.result <= '0;
                  bus.ready  <= DivResultNotReady;
               end else begin
                  work <= work_next;
                  cnt  <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(WIDTH-1)) begin
                     state      <= DivEnd;
                     bus.result <= {rem_fix, quo_fix};
                     bus.ready  <= DivResultReady;
                  end
               end
            end
            DivEnd: begin
               if (bus.annul || bus.start == DivStop) begin
                  state      <= DivFree;
                  bus.result <= '0;
                  bus.ready  <= DivResultNotReady;
               end
            end
            default: state <= DivFree;
         endcase
      end
   end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: arithmetic reference model plus directed literal vectors.
module tb_div;
   import div_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   div_if #(.WIDTH(W)) bus();

   div #(.WIDTH(W), .CNT_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Plain-arithmetic reference: 64-bit signed division truncates toward zero.
   function automatic logic [63:0] ref_div(logic sgn, logic [31:0] a, logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   function automatic int ref_lat(logic sgn, logic [31:0] a, logic [31:0] b);
      logic [31:0] ma, mb;
      if (b == 32'd0) return 2;
      ma = (sgn && a[31]) ? 32'd0 - a : a;
      mb = (sgn && b[31]) ? 32'd0 - b : b;
`ifdef DIV_EARLY_OUT_EN
      if (mb > ma) return 1;
`endif
      if (mb == ma) return 33;
      return 33;
   endfunction

   // Transaction-level expectation: an accepted request produces its result after ref_lat edges.
   int           phase;
   int           m_left;
   logic [63:0]  m_res;
   logic         exp_ready;
   logic [63:0]  exp_result;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase      <= 0;
         m_left     <= 0;
         m_res      <= '0;
         exp_ready  <= 1'b0;
         exp_result <= '0;
      end else begin
         case (phase)
            0: if (bus.start && !bus.annul) begin
               m_res <= ref_div(bus.signed_div, bus.opdata1, bus.opdata2);
               if (ref_lat(bus.signed_div, bus.opdata1, bus.opdata2) == 1) begin
                  phase      <= 2;
                  exp_ready  <= 1'b1;
                  exp_result <= ref_div(bus.signed_div, bus.opdata1, bus.opdata2);
               end else begin
                  phase  <= 1;
                  m_left <= ref_lat(bus.signed_div, bus.opdata1, bus.opdata2) - 1;
               end
            end
            1: if (bus.annul) begin
               phase <= 0;
            end else if (m_left == 1) begin
               phase      <= 2;
               exp_ready  <= 1'b1;
               exp_result <= m_res;
            end else begin
               m_left <= m_left - 1;
            end
            default: if (bus.annul || !bus.start) begin
               phase      <= 0;
               exp_ready  <= 1'b0;
               exp_result <= '0;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         n_tests++;
         if (bus.ready !== exp_ready) begin
            n_fail++;
            $display("FAIL cycle_ready: got %0b expected %0b at %0t", bus.ready, exp_ready, $time);
         end
         if (exp_ready) begin
            n_tests++;
            if (bus.result !== exp_result) begin
               n_fail++;
               $display("FAIL cycle_result: got %h expected %h at %0t", bus.result, exp_result, $time);
            end
         end
      end
   end

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_op(string name, logic sgn, logic [31:0] a, logic [31:0] b,
                         logic [63:0] lit, int lit_edges);
      int edges;
      edges = 0;
      @(negedge clk);
      bus.signed_div = sgn;
      bus.opdata1    = a;
      bus.opdata2    = b;
      bus.start      = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.ready) begin
            edges = i;
            break;
         end
      end
      check({name, "_edges"}, 64'(edges), 64'(lit_edges));
      check({name, "_result"}, bus.result, lit);
      check({name, "_model"}, ref_div(sgn, a, b), lit);
      @(posedge clk);
      #1;
      check({name, "_hold_ready"}, 64'(bus.ready), 64'd1);
      check({name, "_hold_result"}, bus.result, lit);
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      check({name, "_drop_ready"}, 64'(bus.ready), 64'd0);
      check({name, "_drop_result"}, bus.result, 64'd0);
   endtask

   int eo_lat;

   initial begin
`ifdef DIV_EARLY_OUT_EN
      eo_lat = 1;
`else
      eo_lat = 33;
`endif
      bus.signed_div = 1'b0;
      bus.opdata1    = '0;
      bus.opdata2    = '0;
      bus.start      = 1'b0;
      bus.annul      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_ready", 64'(bus.ready), 64'd0);
      check("reset_result", bus.result, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("u_100_7",   1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                33);
      run_op("s_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
      run_op("s_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD},         33);
      run_op("u_div0",    1'b0, 32'h1234,       32'd0,          64'd0,                          2);
      run_op("s_div0",    1'b1, 32'h1234,       32'd0,          64'd0,                          2);
      run_op("s_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000},         33);
      run_op("u_big",     1'b0, 32'hFFFF_FFFF,  32'h10,         {32'hF, 32'h0FFF_FFFF},         33);
      run_op("u_5_9",     1'b0, 32'd5,          32'd9,          {32'd5, 32'd0},                 eo_lat);
      run_op("s_m5_9",    1'b1, 32'hFFFF_FFFB,  32'd9,          {32'hFFFF_FFFB, 32'd0},         eo_lat);

      // start together with annul in FREE must be ignored
      @(negedge clk);
      bus.opdata1 = 32'd50;
      bus.opdata2 = 32'd5;
      bus.start   = 1'b1;
      bus.annul   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("annul_free_ready", 64'(bus.ready), 64'd0);
      @(negedge clk);
      bus.start = 1'b0;
      bus.annul = 1'b0;

      // flush at iteration 10
      @(negedge clk);
      bus.signed_div = 1'b0;
      bus.opdata1    = 32'd100;
      bus.opdata2    = 32'd7;
      bus.start      = 1'b1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk);
      bus.annul = 1'b1;
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      check("annul_on_ready", 64'(bus.ready), 64'd0);
      check("annul_on_result", bus.result, 64'd0);
      @(negedge clk);
      bus.annul = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("annul_stays_idle", 64'(bus.ready), 64'd0);
      run_op("u_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

      // asynchronous reset in the middle of an iteration
      @(negedge clk);
      bus.opdata1 = 32'd100;
      bus.opdata2 = 32'd7;
      bus.start   = 1'b1;
      repeat (6) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_on_ready", 64'(bus.ready), 64'd0);
      check("rst_on_result", bus.result, 64'd0);
      bus.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_op("u_100_7_again", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

      // asynchronous reset while a result is being held
      @(negedge clk);
      bus.opdata1 = 32'd9;
      bus.opdata2 = 32'd3;
      bus.start   = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.ready) break;
      end
      check("end_before_rst", bus.result, {32'd0, 32'd3});
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_end_ready", 64'(bus.ready), 64'd0);
      check("rst_end_result", bus.result, 64'd0);
      bus.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("after_rst_idle", 64'(bus.ready), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

endmodule
